// File: rtl/guvm_mem_pkg.sv
// Shared types and helpers for the bench-side memory responder.
// Response entries are sized for the widest supported bus; instances use the low bits.
package guvm_mem_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 64;
  localparam int unsigned MAX_ADDR_WIDTH = 64;
  localparam int unsigned CNT_WIDTH      = 8;
  localparam int unsigned BYTE_BITS      = 8;
  // Byte-lane count of the default 32-bit port; instances derive their own.
  localparam int unsigned BE_WIDTH       = 32 / BYTE_BITS;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] data;
    logic                      err;
    logic [CNT_WIDTH-1:0]      cnt;
  } rsp_entry_t;

  function automatic logic [MAX_ADDR_WIDTH-1:0] word_index(
    input logic [MAX_ADDR_WIDTH-1:0] addr,
    input int unsigned               off_bits
  );
    return addr >> off_bits;
  endfunction

endpackage

// File: rtl/guvm_rsp_fifo.sv
// In-order response queue; every stored entry counts down to zero and only a
// zero-count head is reported ready.
module guvm_rsp_fifo
  import guvm_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  rsp_entry_t       push_entry_i,
  input  logic             pop_i,
  output rsp_entry_t       head_o,
  output logic             head_ready_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [OCC_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t       slots_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o       = (count_reg == OCC_W'(DEPTH));
  assign empty_o      = (count_reg == '0);
  assign count_o      = count_reg;
  assign head_o       = slots_reg[rd_ptr_reg];
  assign head_ready_o = !empty_o && (head_o.cnt == '0);
  assign do_pop       = pop_i && !empty_o;
  assign do_push      = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) slots_reg[i] <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // Countdowns keep running while the head is stalled.
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (wr_ptr_reg == PTR_W'(i))) begin
          slots_reg[i] <= push_entry_i;
        end else if (slots_reg[i].cnt != '0) begin
          slots_reg[i].cnt <= slots_reg[i].cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/guvm_mem_responder.sv
// Bench-side memory slave for a req/gnt/rvalid port: backing memory, latency,
// in-order outstanding queue, stall and read-data injection, write observation.
module guvm_mem_responder
  import guvm_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RVALID_LAT      = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_i,
  output logic                                 gnt_o,
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  logic                                 we_i,
  input  logic [DATA_WIDTH/8-1:0]              be_i,
  input  logic [DATA_WIDTH-1:0]                wdata_i,
  output logic                                 rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic                                 err_o,
  input  logic                                 gnt_stall_i,
  input  logic                                 rsp_stall_i,
  input  logic                                 inj_en_i,
  input  logic [DATA_WIDTH-1:0]                inj_rdata_i,
  output logic                                 wobs_valid_o,
  output logic [ADDR_WIDTH-1:0]                wobs_addr_o,
  output logic [DATA_WIDTH-1:0]                wobs_data_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned BE_W     = DATA_WIDTH / BYTE_BITS;
  localparam int unsigned OFF_BITS = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned OCC_W    = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0]     mem_reg [MEM_DEPTH];
  logic [MAX_ADDR_WIDTH-1:0] idx_full;
  logic [IDX_W-1:0]          idx;
  logic                      in_range;
  logic [DATA_WIDTH-1:0]     mem_word;
  logic [DATA_WIDTH-1:0]     merged_word;
  logic                      accept;
  logic                      wr_hit;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      head_ready;
  rsp_entry_t                head;
  rsp_entry_t                push_entry;
  logic                      wobs_valid_reg;
  logic [ADDR_WIDTH-1:0]     wobs_addr_reg;
  logic [DATA_WIDTH-1:0]     wobs_data_reg;
  logic                      unused_bits;

  assign idx_full = word_index(MAX_ADDR_WIDTH'(addr_i), OFF_BITS);
  assign idx      = idx_full[IDX_W-1:0];
  assign in_range = (idx_full < MAX_ADDR_WIDTH'(MEM_DEPTH));
  assign mem_word = mem_reg[idx];

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      assign merged_word[gi*BYTE_BITS +: BYTE_BITS] = be_i[gi] ? wdata_i[gi*BYTE_BITS +: BYTE_BITS]
                                                               : mem_word[gi*BYTE_BITS +: BYTE_BITS];
    end
  endgenerate

  // A pop in the same cycle frees a slot, so a full queue can still grant.
  assign pop    = head_ready && !rsp_stall_i;
  assign gnt_o  = req_i && !gnt_stall_i && (!fifo_full || pop);
  assign accept = req_i && gnt_o;
  assign wr_hit = accept && we_i && in_range;

  always_comb begin
    push_entry     = '0;
    push_entry.cnt = CNT_WIDTH'(RVALID_LAT - 1);
    push_entry.err = !in_range;
    if (in_range && !we_i) begin
      push_entry.data = MAX_DATA_WIDTH'(inj_en_i ? inj_rdata_i : mem_word);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_hit) mem_reg[idx] <= merged_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wobs_valid_reg <= 1'b0;
      wobs_addr_reg  <= '0;
      wobs_data_reg  <= '0;
    end else begin
      wobs_valid_reg <= wr_hit;
      if (wr_hit) begin
        wobs_addr_reg <= addr_i;
        wobs_data_reg <= merged_word;
      end
    end
  end

  guvm_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .OCC_W (OCC_W)
  ) u_rsp_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .head_ready_o (head_ready),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (outstanding_o)
  );

  assign rvalid_o     = pop;
  assign rdata_o      = pop ? head.data[DATA_WIDTH-1:0] : '0;
  assign err_o        = pop && head.err;
  assign wobs_valid_o = wobs_valid_reg;
  assign wobs_addr_o  = wobs_addr_reg;
  assign wobs_data_o  = wobs_data_reg;

  assign unused_bits = ^{idx_full, head, fifo_empty};

endmodule

// File: tb/tb_guvm_mem_responder.sv
// Scoreboard bench: a latency-1 instance for memory, stall, error, injection and
// reset behaviour, and a latency-3 instance for the outstanding limit.
module tb_guvm_mem_responder;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_wobs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        req = 0, we = 0, gnt_stall = 0, rsp_stall = 0, inj_en = 0;
  logic [31:0] addr = 0, wdata = 0, inj_rdata = 0;
  logic [3:0]  be = 0;
  logic        gnt, rvalid, err, wobs_valid;
  logic [31:0] rdata, wobs_addr, wobs_data;
  logic [2:0]  outstanding;

  logic        req3 = 0, inj_en3 = 0, rsp_stall3 = 0;
  logic [31:0] inj_rdata3 = 0;
  logic        gnt3, rvalid3, err3, wobs_valid3;
  logic [31:0] rdata3, wobs_addr3, wobs_data3;
  logic [2:0]  outstanding3;

  int total = 0;
  int bad = 0;

  exp_rsp_t  exp_q[$];
  exp_rsp_t  exp3_q[$];
  exp_wobs_t wobs_q[$];
  exp_rsp_t  mon_e, mon3_e;
  exp_wobs_t mon_w;

  always #5 clk = ~clk;

  guvm_mem_responder #(.RVALID_LAT(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .gnt_stall_i(gnt_stall), .rsp_stall_i(rsp_stall), .inj_en_i(inj_en),
    .inj_rdata_i(inj_rdata), .wobs_valid_o(wobs_valid), .wobs_addr_o(wobs_addr),
    .wobs_data_o(wobs_data), .outstanding_o(outstanding)
  );

  guvm_mem_responder #(.RVALID_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .gnt_o(gnt3), .addr_i(32'h0), .we_i(1'b0),
    .be_i(4'h0), .wdata_i(32'h0), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3),
    .gnt_stall_i(1'b0), .rsp_stall_i(rsp_stall3), .inj_en_i(inj_en3),
    .inj_rdata_i(inj_rdata3), .wobs_valid_o(wobs_valid3), .wobs_addr_o(wobs_addr3),
    .wobs_data_o(wobs_data3), .outstanding_o(outstanding3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("rsp   data=%h err=%b", rdata, err);
          chk("rsp_data", 64'(rdata), 64'(mon_e.data));
          chk("rsp_err", 64'(err), 64'(mon_e.err));
        end
      end else begin
        chk("idle_zero", 64'({rdata, err}), 64'd0);
      end
      if (wobs_valid) begin
        if (wobs_q.size() == 0) begin
          chk("wobs_unexpected", 64'd1, 64'd0);
        end else begin
          mon_w = wobs_q.pop_front();
          $display("wobs  addr=%h data=%h", wobs_addr, wobs_data);
          chk("wobs_addr", 64'(wobs_addr), 64'(mon_w.addr));
          chk("wobs_data", 64'(wobs_data), 64'(mon_w.data));
        end
      end
      if (rvalid3) begin
        if (exp3_q.size() == 0) begin
          chk("rsp3_unexpected", 64'd1, 64'd0);
        end else begin
          mon3_e = exp3_q.pop_front();
          $display("rsp3  data=%h err=%b", rdata3, err3);
          chk("rsp3_data", 64'(rdata3), 64'(mon3_e.data));
          chk("rsp3_err", 64'(err3), 64'(mon3_e.err));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request on the latency-1 instance; optionally checks same-cycle grant,
  // rvalid one cycle after accept, and the wobs pulse.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e,
                        input logic exp_wobs, input logic [31:0] wobs_d, input logic lat_chk);
    int n;
    exp_rsp_t  r;
    exp_wobs_t o;
    @(posedge clk); #1;
    req = 1; we = w; addr = a; wdata = d; be = b;
    $display("req   we=%b addr=%h wdata=%h be=%h", w, a, d, b);
    @(negedge clk);
    n = 0;
    while (gnt !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (gnt !== 1'b1) begin
      chk("gnt_timeout", 64'd0, 64'd1);
      req = 0;
      return;
    end
    if (lat_chk) chk("gnt_same_cycle", 64'(n), 64'd0);
    r.data = exp_d;
    r.err  = exp_e;
    exp_q.push_back(r);
    if (exp_wobs) begin
      o.addr = a;
      o.data = wobs_d;
      wobs_q.push_back(o);
    end
    @(posedge clk); #1;
    req = 0; we = 0;
    if (lat_chk) begin
      @(negedge clk);
      chk("rvalid_lat1", 64'(rvalid), 64'd1);
      chk("wobs_pulse", 64'(wobs_valid), 64'(exp_wobs));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] exp_gnt3;
    logic [10:0] exp_rv3;
    int          issued;
    exp_rsp_t    r3;

    // Reset state, sampled while reset is held.
    #12;
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_wobs_valid", 64'(wobs_valid), 64'd0);
    chk("rst_wobs_addr", 64'(wobs_addr), 64'd0);
    chk("rst_wobs_data", 64'(wobs_data), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // Write then read.
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1, 32'hDEADBEEF, 1);
    do_req(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, 1);

    // Byte merge.
    do_req(1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 1, 32'h11223344, 1);
    do_req(1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 1, 32'h11BB33DD, 1);
    do_req(0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 0, 32'h0, 1);

    // Out-of-range read and write: error, no memory update, no wobs.
    do_req(0, 32'h1000, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0, 1);
    do_req(1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 1, 0, 32'h0, 1);

    // Injection, including a change while a read is still queued.
    idle(2);
    inj_en = 1; inj_rdata = 32'h002180B3;
    do_req(0, 32'h10, 32'h0, 4'h0, 32'h002180B3, 0, 0, 32'h0, 1);
    do_req(0, 32'h44, 32'h0, 4'h0, 32'h002180B3, 0, 0, 32'h0, 1);
    idle(2);
    rsp_stall = 1;
    do_req(0, 32'h20, 32'h0, 4'h0, 32'h002180B3, 0, 0, 32'h0, 0);
    inj_en = 0; inj_rdata = 32'h0;
    do_req(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    rsp_stall = 0;
    idle(3);

    // Response and grant stalls.
    rsp_stall = 1;
    do_req(0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 0, 32'h0, 0);
    do_req(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_rvalid", 64'(rvalid), 64'd0);
    end
    chk("stall_occupancy", 64'(outstanding), 64'd2);
    @(posedge clk); #1;
    gnt_stall = 1; req = 1; addr = 32'h30;
    #1 chk("gnt_stall_low", 64'(gnt), 64'd0);
    gnt_stall = 0;
    #1 chk("gnt_after_stall", 64'(gnt), 64'd1);
    req = 0;
    #1 rsp_stall = 0;
    @(negedge clk);
    chk("release_rv0", 64'(rvalid), 64'd1);
    @(negedge clk);
    chk("release_rv1", 64'(rvalid), 64'd1);
    @(negedge clk);
    chk("release_rv2", 64'(rvalid), 64'd0);

    // Outstanding limit on the latency-3 instance; responses held for 5 cycles.
    exp_gnt3 = 11'b00001101111;
    exp_rv3  = 11'b11111100000;
    issued   = 0;
    inj_en3  = 1;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      req3 = (issued < 6);
      rsp_stall3 = (c < 5);
      inj_rdata3 = 32'h100 + 32'(issued);
      @(negedge clk);
      chk("o_gnt", 64'(gnt3), 64'(exp_gnt3[c]));
      chk("o_rvalid", 64'(rvalid3), 64'(exp_rv3[c]));
      if (c == 4) chk("o_full_occ", 64'(outstanding3), 64'd4);
      if (req3 && gnt3) begin
        r3.data = inj_rdata3;
        r3.err  = 1'b0;
        exp3_q.push_back(r3);
        $display("req3  read data_tag=%h", inj_rdata3);
        issued++;
      end
    end
    // Single read: rvalid exactly three cycles after the grant.
    @(posedge clk); #1;
    req3 = 1; inj_rdata3 = 32'h777;
    @(negedge clk);
    chk("lat3_gnt", 64'(gnt3), 64'd1);
    r3.data = 32'h777;
    r3.err  = 1'b0;
    exp3_q.push_back(r3);
    @(posedge clk); #1;
    req3 = 0;
    @(negedge clk); chk("lat3_c1", 64'(rvalid3), 64'd0);
    @(negedge clk); chk("lat3_c2", 64'(rvalid3), 64'd0);
    @(negedge clk); chk("lat3_c3", 64'(rvalid3), 64'd1);

    // Asynchronous reset with three entries queued.
    idle(2);
    rsp_stall = 1;
    do_req(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    do_req(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    do_req(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("pre_rst_occ", 64'(outstanding), 64'd3);
    @(posedge clk); #2;
    rsp_stall = 0;
    #1 rst_n = 0;
    #1;
    chk("async_rst_rvalid", 64'(rvalid), 64'd0);
    chk("async_rst_occ", 64'(outstanding), 64'd0);
    chk("async_rst_rdata", 64'(rdata), 64'd0);
    exp_q.delete();
    idle(2);
    rst_n = 1;
    idle(6);
    chk("post_rst_occ", 64'(outstanding), 64'd0);
    do_req(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, 1);

    idle(3);
    chk("sb_drain", 64'(exp_q.size() + exp3_q.size() + wobs_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
